l1_d_data_array_bursted: RTL and testbench
==========================================

Name: l1_d_data_array_bursted

Overview:
- Parametrised L1 data-cache data array: NUM_SETS x NUM_WAYS lines of LINE_W bits.
- CPU side: single-word reads and byte-enabled writes, with registered read data.
- L2 side: line refill and line eviction in multi-beat bursts of BUS_W bits, under a small FSM.
- Sits between the L1 D-cache controller and the L2 interface; replaces the fixed 32-set, 2-way, single-cycle-refill array.

Parameters:
- NUM_SETS, 32, number of sets; IDX_W = clog2(NUM_SETS).
- NUM_WAYS, 2, associativity; WAY_W = max(1, clog2(NUM_WAYS)).
- LINE_W, 512, line width in bits; OFF_W = clog2(LINE_W/8).
- WORD_W, 32, CPU word width; must be a multiple of 8.
- BUS_W, 128, L2 beat width; LINE_W must be a multiple of BUS_W. BEATS = LINE_W/BUS_W (1 allowed).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_valid  in  1  CPU request valid
- cpu_ready  out  1  request accepted this cycle when cpu_valid && cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_be  in  WORD_W/8  byte enables, writes only
- cpu_index  in  IDX_W  set index
- cpu_way  in  WAY_W  way
- cpu_offset  in  OFF_W  byte offset; low clog2(WORD_W/8) bits ignored
- cpu_wdata  in  WORD_W  write data
- cpu_rdata  out  WORD_W  registered read data
- cpu_rvalid  out  1  one-cycle pulse, read data valid
- refill_start  in  1  start line refill (one-cycle pulse)
- refill_index  in  IDX_W  target set, sampled at start
- refill_way  in  WAY_W  target way, sampled at start
- refill_valid  in  1  refill beat valid
- refill_data  in  BUS_W  refill beat, beat 0 = bits [BUS_W-1:0]
- refill_done  out  1  one-cycle pulse after last beat written
- evict_start  in  1  start line eviction (one-cycle pulse)
- evict_index  in  IDX_W  source set, sampled at start
- evict_way  in  WAY_W  source way, sampled at start
- evict_valid  out  1  eviction beat valid
- evict_ready  in  1  L2 accepts beat
- evict_data  out  BUS_W  eviction beat, beat 0 first
- evict_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Storage: line slot = index*NUM_WAYS + way. Reset clears every line to 0.
- Reset values: FSM IDLE, beat counter 0, cpu_rdata 0, cpu_rvalid/refill_done/evict_done/evict_valid 0.
- Reset mid-burst aborts the burst; no done pulse.
- FSM states IDLE, REFILL, EVICT. Start priority in IDLE: refill_start > evict_start > CPU request.
- A start seen outside IDLE is ignored.
- cpu_ready = (state == IDLE) && !refill_start && !evict_start.
- CPU read: accepted at edge N; cpu_rdata = addressed word and cpu_rvalid = 1 during cycle N+1. cpu_rdata holds between reads.
- CPU write: updates only enabled bytes at edge N; no rvalid pulse.
- A read accepted the cycle after a write to the same word returns the new data.
- Out-of-range index or way (non-power-of-2 parameters): writes dropped, reads return 0 with rvalid.
- REFILL: entered on refill_start; index/way latched; beat counter = 0.
  - Each cycle with refill_valid = 1 writes refill_data into slice [cnt*BUS_W +: BUS_W] and increments cnt.
  - The last beat (cnt == BEATS-1) returns to IDLE and asserts refill_done for the following cycle.
  - Cycles with refill_valid = 0 stall with no change.
  - refill_valid in IDLE or EVICT is ignored.
- EVICT: entered on evict_start; index/way latched; cnt = 0.
  - evict_valid = 1 throughout EVICT; evict_data = slice cnt of the latched line, combinational.
  - evict_data must stay stable while evict_valid && !evict_ready.
  - cnt advances on evict_valid && evict_ready. The last beat accepted returns to IDLE and pulses evict_done the next cycle.
  - evict_data is don't-care outside EVICT; drive 0.
- The line being refilled or evicted is never CPU-accessible mid-burst, because cpu_ready is 0.
- Beat counter width is clog2(BEATS) min 1. It never wraps past BEATS-1.

Test Plan:
- Reset then read set 5 way 1 offset 0x3C: rvalid 1 cycle later, rdata = 0x0000_0000; cpu_ready = 1 in IDLE.
- Write 0xDEADBEEF with be = 4'b0101 to set 3, way 0, offset 8; read back next cycle: rdata = 0x00AD00EF.
- Refill set 7 way 1 with 4 beats 0x…11, 0x…22, 0x…33, 0x…44, with a refill_valid gap after beat 1.
  - cpu_ready = 0 throughout; refill_done pulses once after beat 4.
  - Read offset 0x20 returns the low word of beat 2 (0x…33 pattern).
- Evict set 7 way 1 with evict_ready toggling 1,0,1,1,0,1.
  - Beats appear in order 0..3; data stays stable during stalls; evict_done pulses once after the 4th handshake.
- Simultaneous refill_start, evict_start and cpu_valid in IDLE: refill wins, eviction and CPU request not accepted, cpu_ready = 0.
- Assert rst after refill beat 2: FSM returns to IDLE, no refill_done; all lines read 0; a new refill completes normally.

Source files
------------

// File: rtl/l1_d_data_array_bursted.sv
// L1 data-cache data array: NUM_SETS x NUM_WAYS lines, single-word CPU access with
// registered read data, and multi-beat L2 refill/eviction bursts under a small FSM.
module l1_d_data_array_bursted #(
  parameter int NUM_SETS = 32,
  parameter int NUM_WAYS = 2,
  parameter int LINE_W   = 512,
  parameter int WORD_W   = 32,
  parameter int BUS_W    = 128,
  localparam int IDX_W   = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int OFF_W   = $clog2(LINE_W / 8),
  localparam int BE_W    = WORD_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic [IDX_W-1:0]  cpu_index,
  input  logic [WAY_W-1:0]  cpu_way,
  input  logic [OFF_W-1:0]  cpu_offset,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              refill_start,
  input  logic [IDX_W-1:0]  refill_index,
  input  logic [WAY_W-1:0]  refill_way,
  input  logic              refill_valid,
  input  logic [BUS_W-1:0]  refill_data,
  output logic              refill_done,
  input  logic              evict_start,
  input  logic [IDX_W-1:0]  evict_index,
  input  logic [WAY_W-1:0]  evict_way,
  output logic              evict_valid,
  input  logic              evict_ready,
  output logic [BUS_W-1:0]  evict_data,
  output logic              evict_done,
  output logic [1:0]        dbg_state
);
  // Handshakes: a CPU request transfers on a cycle with cpu_valid && cpu_ready; an
  // eviction beat transfers on evict_valid && evict_ready and evict_data holds until then;
  // refill beats have no backpressure and transfer on every cycle with refill_valid in REFILL.

  localparam int BEATS  = LINE_W / BUS_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINES  = NUM_SETS * NUM_WAYS;
  localparam int SLOT_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int WOFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_EVICT  = 2'd2
  } state_t;

  logic [LINE_W-1:0] mem [LINES];
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] lat_slot_q;
  logic              lat_ok_q;
  logic              refill_done_d, evict_done_d;
  logic              cpu_acc, cpu_ok, last_beat;
  logic [SLOT_W-1:0] cpu_slot;
  int                cpu_word;

  function automatic logic in_range(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way);
    return (int'(idx) < NUM_SETS) && (int'(way) < NUM_WAYS);
  endfunction

  function automatic logic [SLOT_W-1:0] slot_of(input logic [IDX_W-1:0] idx,
                                                input logic [WAY_W-1:0] way);
    return SLOT_W'(int'(idx) * NUM_WAYS + int'(way));
  endfunction

  assign cpu_ready = (state_q == ST_IDLE) && !refill_start && !evict_start;
  assign cpu_acc   = cpu_valid && cpu_ready;
  assign cpu_ok    = in_range(cpu_index, cpu_way);
  assign cpu_slot  = slot_of(cpu_index, cpu_way);
  assign cpu_word  = int'(cpu_offset >> WOFF_W);
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  assign evict_valid = (state_q == ST_EVICT);
  assign dbg_state   = state_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    refill_done_d = 1'b0;
    evict_done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (refill_start) begin
          state_d = ST_REFILL;
          cnt_d   = '0;
        end else if (evict_start) begin
          state_d = ST_EVICT;
          cnt_d   = '0;
        end
      end
      ST_REFILL: begin
        if (refill_valid) begin
          if (last_beat) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            refill_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_EVICT: begin
        if (evict_ready) begin
          if (last_beat) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            evict_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lat_slot_q  <= '0;
      lat_ok_q    <= 1'b0;
      refill_done <= 1'b0;
      evict_done  <= 1'b0;
      cpu_rdata   <= '0;
      cpu_rvalid  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      refill_done <= refill_done_d;
      evict_done  <= evict_done_d;
      if (state_q == ST_IDLE && refill_start) begin
        lat_slot_q <= slot_of(refill_index, refill_way);
        lat_ok_q   <= in_range(refill_index, refill_way);
      end else if (state_q == ST_IDLE && evict_start) begin
        lat_slot_q <= slot_of(evict_index, evict_way);
        lat_ok_q   <= in_range(evict_index, evict_way);
      end
      cpu_rvalid <= cpu_acc && !cpu_we;
      if (cpu_acc && !cpu_we)
        cpu_rdata <= cpu_ok ? mem[cpu_slot][cpu_word*WORD_W +: WORD_W] : '0;
    end
  end

  // Refill and CPU writes never coincide: CPU access is only accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) mem[i] <= '0;
    end else begin
      if (state_q == ST_REFILL && refill_valid && lat_ok_q)
        mem[lat_slot_q][int'(cnt_q)*BUS_W +: BUS_W] <= refill_data;
      if (cpu_acc && cpu_we && cpu_ok)
        for (int b = 0; b < BE_W; b++)
          if (cpu_be[b]) mem[cpu_slot][cpu_word*WORD_W + b*8 +: 8] <= cpu_wdata[b*8 +: 8];
    end
  end

  always_comb begin
    evict_data = '0;
    if (state_q == ST_EVICT && lat_ok_q)
      evict_data = mem[lat_slot_q][int'(cnt_q)*BUS_W +: BUS_W];
  end

endmodule

// File: tb/tb_l1_d_data_array_bursted.sv
// Directed bench for l1_d_data_array_bursted: CPU read/write, bursted refill and
// eviction, start priority and reset mid-burst, all with hand-computed expectations.
module tb_l1_d_data_array_bursted;
  localparam int BUS_W = 128;

  logic         clk, rst;
  logic         cpu_valid, cpu_ready, cpu_we;
  logic [3:0]   cpu_be;
  logic [4:0]   cpu_index;
  logic [0:0]   cpu_way;
  logic [5:0]   cpu_offset;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_rvalid;
  logic         refill_start, refill_valid, refill_done;
  logic [4:0]   refill_index;
  logic [0:0]   refill_way;
  logic [127:0] refill_data;
  logic         evict_start, evict_valid, evict_ready, evict_done;
  logic [4:0]   evict_index;
  logic [0:0]   evict_way;
  logic [127:0] evict_data;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BUS_W-1:0] exp_q[$];

  l1_d_data_array_bursted dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_index(cpu_index), .cpu_way(cpu_way), .cpu_offset(cpu_offset),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .refill_start(refill_start), .refill_index(refill_index), .refill_way(refill_way),
    .refill_valid(refill_valid), .refill_data(refill_data), .refill_done(refill_done),
    .evict_start(evict_start), .evict_index(evict_index), .evict_way(evict_way),
    .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_data(evict_data),
    .evict_done(evict_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [BUS_W-1:0] beat_of(input logic [7:0] b);
    return {(BUS_W/8){b}};
  endfunction

  // driver tasks
  task automatic idle_inputs();
    cpu_valid = 0; cpu_we = 0; cpu_be = '0; cpu_index = '0; cpu_way = '0;
    cpu_offset = '0; cpu_wdata = '0;
    refill_start = 0; refill_index = '0; refill_way = '0; refill_valid = 0; refill_data = '0;
    evict_start = 0; evict_index = '0; evict_way = '0; evict_ready = 0;
  endtask

  task automatic cpu_read(input logic [4:0] idx, input logic way, input logic [5:0] off,
                          output logic [31:0] data, output logic rv, output logic rv_after);
    @(negedge clk);
    cpu_valid = 1; cpu_we = 0; cpu_be = '0; cpu_index = idx; cpu_way = way; cpu_offset = off;
    @(negedge clk);
    cpu_valid = 0;
    rv = cpu_rvalid; data = cpu_rdata;
    @(negedge clk);
    rv_after = cpu_rvalid;
  endtask

  task automatic cpu_write(input logic [4:0] idx, input logic way, input logic [5:0] off,
                           input logic [3:0] be, input logic [31:0] data);
    @(negedge clk);
    cpu_valid = 1; cpu_we = 1; cpu_be = be; cpu_index = idx; cpu_way = way;
    cpu_offset = off; cpu_wdata = data;
    @(negedge clk);
    cpu_valid = 0; cpu_we = 0;
  endtask

  // Sends four beats whose bytes come from bytes[k*8 +: 8]; gap inserts an idle
  // cycle after beat 1. Returns what was observed on the DUT along the way.
  task automatic drive_refill(input logic [4:0] idx, input logic way, input logic [31:0] bytes,
                              input logic gap, output logic start_ready,
                              output int during_done, output int during_ready,
                              output logic done_now, output logic done_after);
    int k;
    during_done = 0; during_ready = 0; k = 0;
    @(negedge clk);
    refill_start = 1; refill_index = idx; refill_way = way;
    #1 start_ready = cpu_ready;
    @(negedge clk);
    refill_start = 0;
    for (int step = 0; step < (gap ? 5 : 4); step++) begin
      if (refill_done) during_done++;
      if (cpu_ready) during_ready++;
      if (gap && step == 2) begin
        refill_valid = 0;
      end else begin
        refill_valid = 1; refill_data = beat_of(bytes[k*8 +: 8]); k++;
      end
      @(negedge clk);
    end
    refill_valid = 0;
    done_now = refill_done;
    @(negedge clk);
    done_after = refill_done;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", cpu_rvalid); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
    n_checks++; if (refill_done !== 1'b0 || evict_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b%b expected 00", refill_done, evict_done); end
    n_checks++; if (evict_valid !== 1'b0) begin n_fail++; $display("FAIL reset_evict_valid: got %b expected 0", evict_valid); end
    n_checks++; if (evict_data !== '0) begin n_fail++; $display("FAIL reset_evict_data: got %h expected 0", evict_data); end
    n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cpu_ready); end
  endtask

  task automatic test_reset_read();
    logic [31:0] d; logic rv, rva;
    cpu_read(5'd5, 1'b1, 6'h3C, d, rv, rva);
    n_checks++; if (rv !== 1'b1) begin n_fail++; $display("FAIL rd0_rvalid: got %b expected 1", rv); end
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rd0_data: got %h expected 00000000", d); end
    n_checks++; if (rva !== 1'b0) begin n_fail++; $display("FAIL rd0_rvalid_pulse: got %b expected 0", rva); end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic rv, rva;
    @(negedge clk);
    cpu_valid = 1; cpu_we = 1; cpu_be = 4'b0101; cpu_index = 5'd3; cpu_way = 1'b0;
    cpu_offset = 6'h08; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    cpu_we = 0; cpu_be = '0;
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b expected 0", cpu_rvalid); end
    @(negedge clk);
    cpu_valid = 0;
    n_checks++; if (cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_rvalid: got %b expected 1", cpu_rvalid); end
    n_checks++; if (cpu_rdata !== 32'h00AD00EF) begin n_fail++; $display("FAIL wr_rd_data: got %h expected 00ad00ef", cpu_rdata); end
    @(negedge clk);
    n_checks++; if (cpu_rdata !== 32'h00AD00EF || cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rdata_hold: got %h/%b expected 00ad00ef/0", cpu_rdata, cpu_rvalid); end
    cpu_write(5'd3, 1'b0, 6'h08, 4'b1010, 32'h11223344);
    cpu_read(5'd3, 1'b0, 6'h0B, d, rv, rva);
    n_checks++; if (d !== 32'h11AD33EF || rv !== 1'b1) begin n_fail++; $display("FAIL be_merge: got %h/%b expected 11ad33ef/1", d, rv); end
    cpu_read(5'd3, 1'b0, 6'h0C, d, rv, rva);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL neighbour_word: got %h expected 0", d); end
  endtask

  task automatic test_refill();
    logic sr, dn, da; int dd, dr;
    logic [31:0] d; logic rv, rva;
    drive_refill(5'd7, 1'b1, 32'h44332211, 1'b1, sr, dd, dr, dn, da);
    n_checks++; if (sr !== 1'b0) begin n_fail++; $display("FAIL refill_start_ready: got %b expected 0", sr); end
    n_checks++; if (dr !== 0) begin n_fail++; $display("FAIL refill_ready_busy: got %0d cycles expected 0", dr); end
    n_checks++; if (dd !== 0) begin n_fail++; $display("FAIL refill_done_early: got %0d expected 0", dd); end
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL refill_done: got %b expected 1", dn); end
    n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL refill_done_pulse: got %b expected 0", da); end
    n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL refill_ready_after: got %b expected 1", cpu_ready); end
    cpu_read(5'd7, 1'b1, 6'h20, d, rv, rva);
    n_checks++; if (d !== 32'h33333333) begin n_fail++; $display("FAIL refill_beat2: got %h expected 33333333", d); end
    cpu_read(5'd7, 1'b1, 6'h00, d, rv, rva);
    n_checks++; if (d !== 32'h11111111) begin n_fail++; $display("FAIL refill_beat0: got %h expected 11111111", d); end
    cpu_read(5'd7, 1'b1, 6'h14, d, rv, rva);
    n_checks++; if (d !== 32'h22222222) begin n_fail++; $display("FAIL refill_beat1: got %h expected 22222222", d); end
    cpu_read(5'd7, 1'b1, 6'h3C, d, rv, rva);
    n_checks++; if (d !== 32'h44444444) begin n_fail++; $display("FAIL refill_beat3: got %h expected 44444444", d); end
  endtask

  task automatic test_evict();
    logic [5:0] pat;
    pat = 6'b101101;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(beat_of(8'h11 * 8'(k + 1)));
    @(negedge clk);
    evict_start = 1; evict_index = 5'd7; evict_way = 1'b1;
    #1;
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL evict_start_ready: got %b expected 0", cpu_ready); end
    @(negedge clk);
    evict_start = 0;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (evict_done !== 1'b0) begin n_fail++; $display("FAIL evict_done_early step %0d: got %b expected 0", i, evict_done); end
      evict_ready = pat[i];
      #1;
      n_checks++; if (evict_valid !== 1'b1 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL evict_valid step %0d: got %b/%b expected 1/0", i, evict_valid, cpu_ready); end
      n_checks++; if (evict_data !== exp_q[0]) begin n_fail++; $display("FAIL evict_data step %0d: got %h expected %h", i, evict_data, exp_q[0]); end
      if (pat[i]) void'(exp_q.pop_front());
      @(negedge clk);
    end
    evict_ready = 0;
    n_checks++; if (evict_done !== 1'b1) begin n_fail++; $display("FAIL evict_done: got %b expected 1", evict_done); end
    n_checks++; if (evict_valid !== 1'b0 || evict_data !== '0) begin n_fail++; $display("FAIL evict_idle: got %b/%h expected 0/0", evict_valid, evict_data); end
    @(negedge clk);
    n_checks++; if (evict_done !== 1'b0) begin n_fail++; $display("FAIL evict_done_pulse: got %b expected 0", evict_done); end
  endtask

  task automatic test_priority();
    logic [31:0] d; logic rv, rva;
    @(negedge clk);
    refill_start = 1; refill_index = 5'd2; refill_way = 1'b0;
    evict_start = 1; evict_index = 5'd3; evict_way = 1'b0;
    cpu_valid = 1; cpu_we = 1; cpu_be = 4'hF; cpu_index = 5'd0; cpu_way = 1'b0;
    cpu_offset = 6'h00; cpu_wdata = 32'hCAFEF00D;
    #1;
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready: got %b expected 0", cpu_ready); end
    @(negedge clk);
    refill_start = 0; evict_start = 0; cpu_valid = 0; cpu_we = 0;
    n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL prio_state: got %0d expected 1", dbg_state); end
    n_checks++; if (evict_valid !== 1'b0) begin n_fail++; $display("FAIL prio_evict_valid: got %b expected 0", evict_valid); end
    for (int k = 0; k < 4; k++) begin
      refill_valid = 1; refill_data = beat_of(8'hA1 + 8'(k));
      evict_start = (k == 1);
      @(negedge clk);
    end
    refill_valid = 0; evict_start = 0;
    n_checks++; if (refill_done !== 1'b1 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL prio_refill_done: got %b/%0d expected 1/0", refill_done, dbg_state); end
    @(negedge clk);
    n_checks++; if (evict_valid !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL busy_start_ignored: got %b/%0d expected 0/0", evict_valid, dbg_state); end
    refill_valid = 1; refill_data = '1;
    @(negedge clk);
    refill_valid = 0;
    cpu_read(5'd0, 1'b0, 6'h00, d, rv, rva);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL prio_cpu_dropped: got %h expected 0", d); end
    cpu_read(5'd2, 1'b0, 6'h00, d, rv, rva);
    n_checks++; if (d !== 32'hA1A1A1A1) begin n_fail++; $display("FAIL idle_refill_valid_ignored: got %h expected a1a1a1a1", d); end
    cpu_read(5'd2, 1'b0, 6'h14, d, rv, rva);
    n_checks++; if (d !== 32'hA2A2A2A2) begin n_fail++; $display("FAIL prio_refill_beat1: got %h expected a2a2a2a2", d); end
  endtask

  task automatic test_reset_mid();
    logic sr, dn, da; int dd, dr;
    logic [31:0] d; logic rv, rva;
    @(negedge clk);
    refill_start = 1; refill_index = 5'd4; refill_way = 1'b0;
    @(negedge clk);
    refill_start = 0; refill_valid = 1; refill_data = beat_of(8'h55);
    @(negedge clk);
    refill_data = beat_of(8'h66);
    @(negedge clk);
    refill_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    n_checks++; if (dbg_state !== 2'd0 || cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_state: got %0d/%b expected 0/1", dbg_state, cpu_ready); end
    n_checks++; if (refill_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", refill_done); end
    @(negedge clk);
    n_checks++; if (refill_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done_late: got %b expected 0", refill_done); end
    cpu_read(5'd4, 1'b0, 6'h00, d, rv, rva);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_clear_s4: got %h expected 0", d); end
    cpu_read(5'd7, 1'b1, 6'h20, d, rv, rva);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_clear_s7: got %h expected 0", d); end
    cpu_read(5'd3, 1'b0, 6'h08, d, rv, rva);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_clear_s3: got %h expected 0", d); end
    cpu_read(5'd2, 1'b0, 6'h00, d, rv, rva);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_clear_s2: got %h expected 0", d); end
    drive_refill(5'd4, 1'b0, 32'hAA998877, 1'b0, sr, dd, dr, dn, da);
    n_checks++; if (dn !== 1'b1 || da !== 1'b0 || dd !== 0) begin n_fail++; $display("FAIL rst_new_refill_done: got %b/%b/%0d expected 1/0/0", dn, da, dd); end
    n_checks++; if (dr !== 0) begin n_fail++; $display("FAIL rst_new_refill_ready: got %0d expected 0", dr); end
    cpu_read(5'd4, 1'b0, 6'h30, d, rv, rva);
    n_checks++; if (d !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL rst_new_refill_beat3: got %h expected aaaaaaaa", d); end
    cpu_read(5'd4, 1'b0, 6'h04, d, rv, rva);
    n_checks++; if (d !== 32'h77777777) begin n_fail++; $display("FAIL rst_new_refill_beat0: got %h expected 77777777", d); end
  endtask

  initial begin
    test_reset();
    test_reset_read();
    test_write_read();
    test_refill();
    test_evict();
    test_priority();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
